// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Next-PC controller for the 64-bit pipelined RISC-V core. It decides what
//   the program-counter register loads each cycle and when it loads.
//   Redirect priority is trap > EX branch > ID jump; otherwise it fetches
//   sequentially. It also applies hazard stalls, holds a redirect while
//   instruction memory is busy, and raises pipeline flushes.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   pc_cur              current PC register value
//   stall               load-use stall from the hazard unit
//   br_taken/br_target  EX-stage taken branch / mispredict and its target
//   jal_req/jal_target  ID-stage unconditional jump and its target
//   trap_req/trap_vector trap request and handler address
//   halt_req, resume    enter / leave HALT
//   imem_ready          instruction memory accepts a fetch this cycle
//   pc_next, pc_en      PC register load value and load enable
//   imem_req            fetch request to instruction memory
//   flush_if_id/id_ex   squash the IF/ID and ID/EX pipeline registers
//   misalign            sticky flag: a redirect target with bits[1:0]!=0 was taken
//   st                  state: 0 BOOT, 1 RUN, 2 WAIT_MEM, 3 HALT
module pc_sequencer #(
  parameter int              N            = 64,
  parameter logic [N-1:0]    RESET_VECTOR = '0,
  parameter int              BOOT_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc_cur,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         jal_req,
  input  logic [N-1:0] jal_target,
  input  logic         trap_req,
  input  logic [N-1:0] trap_vector,
  input  logic         halt_req,
  input  logic         resume,
  input  logic         imem_ready,
  output logic [N-1:0] pc_next,
  output logic         pc_en,
  output logic         imem_req,
  output logic         flush_if_id,
  output logic         flush_id_ex,
  output logic         misalign,
  output logic [1:0]   st
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_MEM = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam int            CW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  state_t         r_st, w_st_next;
  logic [CW-1:0]  r_boot_cnt, w_boot_cnt_next;
  logic           r_pend_valid, w_pend_valid_next;
  logic [N-1:0]   r_pend_target, w_pend_target_next;
  logic           r_misalign;
  logic           w_mis_set;

  // Redirect selection
  logic           w_redir;
  logic [N-1:0]   w_raw_target;
  logic [N-1:0]   w_target;
  logic           w_flush_ex;
  logic           w_raw_mis;

  always_comb begin
    w_redir = trap_req | br_taken | jal_req;
    if (trap_req)
      w_raw_target = trap_vector;
    else if (br_taken)
      w_raw_target = br_target;
    else
      w_raw_target = jal_target;
    w_target   = {w_raw_target[N-1:2], 2'b00};
    w_raw_mis  = (w_raw_target[1:0] != 2'b00);
    // A jump from ID only has the IF/ID instruction behind it; trap and
    // branch also kill the instruction already in ID/EX.
    w_flush_ex = trap_req | br_taken;
  end

  // Next-state and output logic
  always_comb begin
    w_st_next          = r_st;
    w_boot_cnt_next    = r_boot_cnt;
    w_pend_valid_next  = r_pend_valid;
    w_pend_target_next = r_pend_target;
    w_mis_set          = 1'b0;
    pc_next            = pc_cur;
    pc_en              = 1'b0;
    imem_req           = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_ex        = 1'b0;

    unique case (r_st)
      S_BOOT: begin
        pc_next = RESET_VECTOR;
        if (r_boot_cnt == BOOT_LAST) begin
          pc_en           = 1'b1;
          w_boot_cnt_next = '0;
          w_st_next       = S_RUN;
        end else begin
          w_boot_cnt_next = r_boot_cnt + 1'b1;
        end
      end

      S_RUN: begin
        imem_req = 1'b1;
        if (w_redir) begin
          // Redirect wins over stall and halt; flushes fire even if the
          // load itself must wait for memory.
          flush_if_id = 1'b1;
          flush_id_ex = w_flush_ex;
          w_mis_set   = w_raw_mis;
          if (imem_ready) begin
            pc_next = w_target;
            pc_en   = 1'b1;
          end else begin
            w_pend_target_next = w_target;
            w_pend_valid_next  = 1'b1;
            w_st_next          = S_WAIT_MEM;
          end
        end else if (halt_req) begin
          w_st_next = S_HALT;
        end else if (!stall && imem_ready) begin
          pc_next = pc_cur + N'(4);
          pc_en   = 1'b1;
        end
      end

      S_WAIT_MEM: begin
        imem_req = 1'b1;
        if (w_redir) begin
          // Any newer redirect is younger in program order, so it replaces
          // the pending one regardless of its source priority.
          flush_if_id = 1'b1;
          flush_id_ex = w_flush_ex;
          w_mis_set   = w_raw_mis;
          if (imem_ready) begin
            pc_next           = w_target;
            pc_en             = 1'b1;
            w_pend_valid_next = 1'b0;
            w_st_next         = S_RUN;
          end else begin
            w_pend_target_next = w_target;
          end
        end else if (imem_ready && r_pend_valid) begin
          pc_next           = r_pend_target;
          pc_en             = 1'b1;
          w_pend_valid_next = 1'b0;
          w_st_next         = S_RUN;
        end
      end

      S_HALT: begin
        if (trap_req) begin
          // Trap loads immediately; the fetch goes out from RUN next cycle.
          pc_next     = w_target;
          pc_en       = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          w_mis_set   = w_raw_mis;
          w_st_next   = S_RUN;
        end else if (resume) begin
          w_st_next = S_RUN;
        end
      end

      default: w_st_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st          <= S_BOOT;
      r_boot_cnt    <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_st          <= w_st_next;
      r_boot_cnt    <= w_boot_cnt_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_target <= w_pend_target_next;
      r_misalign    <= r_misalign | w_mis_set;
    end
  end

  assign misalign = r_misalign;
  assign st       = r_st;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int          N  = 64;
  localparam logic [63:0] RV = 64'h1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pc_cur = '0;
  logic         stall = 1'b0;
  logic         br_taken = 1'b0;
  logic [N-1:0] br_target = '0;
  logic         jal_req = 1'b0;
  logic [N-1:0] jal_target = '0;
  logic         trap_req = 1'b0;
  logic [N-1:0] trap_vector = '0;
  logic         halt_req = 1'b0;
  logic         resume = 1'b0;
  logic         imem_ready = 1'b1;
  logic [N-1:0] pc_next;
  logic         pc_en;
  logic         imem_req;
  logic         flush_if_id;
  logic         flush_id_ex;
  logic         misalign;
  logic [1:0]   st;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .N            (N),
    .RESET_VECTOR (RV),
    .BOOT_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jal_req     (jal_req),
    .jal_target  (jal_target),
    .trap_req    (trap_req),
    .trap_vector (trap_vector),
    .halt_req    (halt_req),
    .resume      (resume),
    .imem_ready  (imem_ready),
    .pc_next     (pc_next),
    .pc_en       (pc_en),
    .imem_req    (imem_req),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .misalign    (misalign),
    .st          (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("check %s: 0x%0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled 1 time unit later, well away from either edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; jal_req = 0; trap_req = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_st", 64'(st), 64'd0);
    chk("rst_pc_en", 64'(pc_en), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_pc_next", pc_next, RV);
    chk("rst_flush_if", 64'(flush_if_id), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);

    // Boot: one idle cycle, then load of the reset vector
    cyc(); rst = 0; #1;
    chk("boot_idle_pc_en", 64'(pc_en), 64'd0);
    cyc(); #1;
    chk("boot_load_pc_en", 64'(pc_en), 64'd1);
    chk("boot_load_pc_next", pc_next, 64'h1000);
    cyc(); pc_cur = 64'h1000; #1;
    chk("run_st", 64'(st), 64'd1);
    chk("seq1_pc_next", pc_next, 64'h1004);
    chk("seq1_imem_req", 64'(imem_req), 64'd1);
    cyc(); pc_cur = 64'h1004; #1;
    chk("seq2_pc_next", pc_next, 64'h1008);

    // Stall for three cycles, then sequential again
    cyc(); pc_cur = 64'h2000; stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_pc_en", i), 64'(pc_en), 64'd0);
      cyc();
    end
    stall = 0; #1;
    chk("post_stall_pc_en", 64'(pc_en), 64'd1);
    chk("post_stall_pc_next", pc_next, 64'h2004);
    cyc(); stall = 1; br_taken = 1; br_target = 64'h3000; #1;
    chk("br_stall_pc_en", 64'(pc_en), 64'd1);
    chk("br_stall_pc_next", pc_next, 64'h3000);
    chk("br_flush_if", 64'(flush_if_id), 64'd1);
    chk("br_flush_ex", 64'(flush_id_ex), 64'd1);

    // Priority: trap > branch > jal
    cyc(); clr(); trap_req = 1; trap_vector = 64'h80; br_taken = 1; jal_req = 1; jal_target = 64'h4000; #1;
    chk("prio_pc_next", pc_next, 64'h80);
    chk("prio_flush_if", 64'(flush_if_id), 64'd1);
    chk("prio_flush_ex", 64'(flush_id_ex), 64'd1);
    cyc(); clr(); jal_req = 1; #1;
    chk("jal_pc_next", pc_next, 64'h4000);
    chk("jal_flush_if", 64'(flush_if_id), 64'd1);
    chk("jal_flush_ex", 64'(flush_id_ex), 64'd0);

    // Redirect while memory busy, overwritten by a younger jal
    cyc(); clr(); imem_ready = 0; br_taken = 1; br_target = 64'h5000; #1;
    chk("wm_br_pc_en", 64'(pc_en), 64'd0);
    chk("wm_br_flush_ex", 64'(flush_id_ex), 64'd1);
    cyc(); clr(); stall = 1; #1;
    chk("wm_st", 64'(st), 64'd2);
    chk("wm_hold_pc_en", 64'(pc_en), 64'd0);
    cyc(); clr(); jal_req = 1; jal_target = 64'h6000; #1;
    chk("wm_jal_flush_if", 64'(flush_if_id), 64'd1);
    chk("wm_jal_flush_ex", 64'(flush_id_ex), 64'd0);
    chk("wm_jal_pc_en", 64'(pc_en), 64'd0);
    cyc(); clr(); imem_ready = 1; #1;
    chk("wm_done_pc_next", pc_next, 64'h6000);
    chk("wm_done_pc_en", 64'(pc_en), 64'd1);
    cyc(); #1;
    chk("wm_back_run", 64'(st), 64'd1);

    // Halt, branch/jal ignored, then trap out
    pc_cur = 64'h6000; halt_req = 1; #1;
    chk("halt_req_pc_en", 64'(pc_en), 64'd0);
    cyc(); clr(); #1;
    chk("halt_st", 64'(st), 64'd3);
    chk("halt_imem_req", 64'(imem_req), 64'd0);
    for (int i = 0; i < 10; i++) begin
      br_taken = (i == 4); jal_req = (i == 7);
      #1;
      chk($sformatf("halt%0d_pc_en", i), 64'(pc_en), 64'd0);
      cyc();
    end
    clr(); trap_req = 1; trap_vector = 64'h100; #1;
    chk("halt_trap_pc_next", pc_next, 64'h100);
    chk("halt_trap_pc_en", 64'(pc_en), 64'd1);
    chk("halt_trap_flush_ex", 64'(flush_id_ex), 64'd1);
    cyc(); clr(); #1;
    chk("halt_trap_st", 64'(st), 64'd1);

    // Halt again, leave via resume
    pc_cur = 64'h100; halt_req = 1;
    cyc(); clr(); resume = 1; #1;
    chk("resume_pc_en", 64'(pc_en), 64'd0);
    cyc(); clr(); #1;
    chk("resume_st", 64'(st), 64'd1);
    chk("resume_pc_next", pc_next, 64'h104);

    // Redirect beats halt
    cyc(); halt_req = 1; jal_req = 1; jal_target = 64'h4400; #1;
    chk("halt_vs_jal_pc_en", 64'(pc_en), 64'd1);
    cyc(); clr(); #1;
    chk("halt_vs_jal_st", 64'(st), 64'd1);

    // Wrap-around and misaligned target
    pc_cur = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    chk("wrap_pc_next", pc_next, 64'h0);
    cyc(); pc_cur = 64'h0; br_taken = 1; br_target = 64'h7003; #1;
    chk("mis_pc_next", pc_next, 64'h7000);
    chk("mis_before_edge", 64'(misalign), 64'd0);
    cyc(); clr(); #1;
    chk("mis_set", 64'(misalign), 64'd1);
    cyc(); cyc(); #1;
    chk("mis_sticky", 64'(misalign), 64'd1);

    // Reset in the middle of WAIT_MEM
    imem_ready = 0; br_taken = 1; br_target = 64'h5000;
    cyc(); clr(); #1;
    chk("rst_wm_pre_st", 64'(st), 64'd2);
    rst = 1; #1;
    chk("rst_wm_st", 64'(st), 64'd0);
    chk("rst_wm_pc_en", 64'(pc_en), 64'd0);
    chk("rst_wm_imem_req", 64'(imem_req), 64'd0);
    chk("rst_wm_pc_next", pc_next, RV);
    chk("rst_wm_misalign", 64'(misalign), 64'd0);
    chk("rst_wm_flush_if", 64'(flush_if_id), 64'd0);
    imem_ready = 1; #1; rst = 0;
    cyc(); #1;
    chk("reboot_pc_en", 64'(pc_en), 64'd1);
    chk("reboot_pc_next", pc_next, 64'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
